// File: rtl/fib_reverse_walker.sv
// ============================================================================
// Module   : fib_reverse_walker
// Brief    : Walks a consecutive Fibonacci pair (F(n), F(n+1)) back to (0, 1)
//            by subtraction and reports n, or flags the pair as invalid.
//            Optional macro FIB_STEP_LIMIT_EN bounds the walk to MAX_STEPS.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_reverse_walker #(
    parameter int WIDTH     = 4,
    parameter int IDX_W     = 4,
    parameter int MAX_STEPS = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] term_lo,
    input  logic [WIDTH-1:0] term_hi,
    output logic             busy,
    output logic             step_valid,
    output logic [WIDTH-1:0] term_out,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] index
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
    logic [WIDTH-1:0] r_term_out, w_term_out_nxt;
    logic [IDX_W-1:0] r_index, w_index_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_step_valid, w_step_valid_nxt;
    logic             r_done, w_done_nxt;
    logic             r_error, w_error_nxt;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;

    // A MAX_STEPS at or above 2**IDX_W could never be matched by the counter.
    if (MAX_STEPS >= (1 << IDX_W)) begin : g_max_steps_range_check
        $error("fib_reverse_walker: MAX_STEPS must be less than 2**IDX_W");
    end

`ifdef FIB_STEP_LIMIT_EN
    localparam logic [IDX_W-1:0] c_max_steps = IDX_W'(MAX_STEPS);
`endif

    assign w_diff   = r_b - r_a;
    assign w_borrow = (r_b < r_a);

    always_comb begin
        w_state_nxt      = r_state;
        w_a_nxt          = r_a;
        w_b_nxt          = r_b;
        w_term_out_nxt   = r_term_out;
        w_index_nxt      = r_index;
        w_busy_nxt       = r_busy;
        w_step_valid_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        w_error_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_a_nxt     = term_lo;
                    w_b_nxt     = term_hi;
                    w_index_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_WALK;
                end
            end
            ST_WALK: begin
                if (r_a == '0 && r_b == WIDTH'(1)) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_a == '0 || w_borrow) begin
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
`ifdef FIB_STEP_LIMIT_EN
                end else if (r_index == c_max_steps) begin
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    // Inverse of the generator's add: (a, b) -> (b - a, a).
                    w_a_nxt          = w_diff;
                    w_b_nxt          = r_a;
                    w_index_nxt      = r_index + IDX_W'(1);
                    w_term_out_nxt   = w_diff;
                    w_step_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_term_out   <= '0;
            r_index      <= '0;
            r_busy       <= 1'b0;
            r_step_valid <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_term_out   <= w_term_out_nxt;
            r_index      <= w_index_nxt;
            r_busy       <= w_busy_nxt;
            r_step_valid <= w_step_valid_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
        end
    end

    assign busy       = r_busy;
    assign step_valid = r_step_valid;
    assign term_out   = r_term_out;
    assign done       = r_done;
    assign error      = r_error;
    assign index      = r_index;

endmodule

`default_nettype wire

// File: tb/tb_fib_reverse_walker.sv
// ============================================================================
// Module   : tb_fib_reverse_walker
// Brief    : Directed self-checking bench for fib_reverse_walker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fib_reverse_walker;

    localparam int WIDTH     = 4;
    localparam int IDX_W     = 4;
    localparam int MAX_STEPS = 3;

`ifdef FIB_STEP_LIMIT_EN
    localparam int c_n_8_13    = 3;
    localparam bit c_done_8_13 = 1'b0;
`else
    localparam int c_n_8_13    = 6;
    localparam bit c_done_8_13 = 1'b1;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] term_lo;
    logic [WIDTH-1:0] term_hi;
    logic             busy;
    logic             step_valid;
    logic [WIDTH-1:0] term_out;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] index;

    int n_checks = 0;
    int n_pass   = 0;

    fib_reverse_walker #(
        .WIDTH     (WIDTH),
        .IDX_W     (IDX_W),
        .MAX_STEPS (MAX_STEPS)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .term_lo    (term_lo),
        .term_hi    (term_hi),
        .busy       (busy),
        .step_valid (step_valid),
        .term_out   (term_out),
        .done       (done),
        .error      (error),
        .index      (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Terms are packed 4 bits each, first derived term in bits [3:0].
    // inject_at >= 1 pulses start with (0, 1) after that step to probe busy-ignore.
    task automatic run_walk(input string tag, input logic [WIDTH-1:0] lo,
                            input logic [WIDTH-1:0] hi, input int exp_steps,
                            input bit exp_done, input logic [23:0] exp_terms,
                            input int inject_at);
        start   = 1'b1;
        term_lo = lo;
        term_hi = hi;
        tick();
        start = 1'b0;
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        for (int i = 0; i < exp_steps; i++) begin
            tick();
            start = 1'b0;
            check({tag, ".sv"},   32'(step_valid), 32'd1);
            check({tag, ".term"}, 32'(term_out), 32'(exp_terms[i*4 +: 4]));
            check({tag, ".idx"},  32'(index), 32'(i + 1));
            check({tag, ".busy"}, 32'(busy), 32'd1);
            if (i + 1 == inject_at) begin
                start   = 1'b1;
                term_lo = 4'd0;
                term_hi = 4'd1;
            end
        end
        tick();
        start = 1'b0;
        check({tag, ".done"},     32'(done), 32'(exp_done));
        check({tag, ".error"},    32'(error), 32'(!exp_done));
        check({tag, ".idx_fin"},  32'(index), 32'(exp_steps));
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
        check({tag, ".sv_off"},   32'(step_valid), 32'd0);
        tick();
        check({tag, ".done_pulse"},  32'(done), 32'd0);
        check({tag, ".error_pulse"}, 32'(error), 32'd0);
        check({tag, ".idx_hold"},    32'(index), 32'(exp_steps));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        term_lo = '0;
        term_hi = '0;
        tick();
        tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.sv",   32'(step_valid), 32'd0);
        check("rst.term", 32'(term_out), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err",  32'(error), 32'd0);
        check("rst.idx",  32'(index), 32'd0);
        rst = 1'b0;
        tick();

        run_walk("p01",  4'd0, 4'd1,  0, 1'b1, 24'h000000, 0);
        run_walk("p813", 4'd8, 4'd13, c_n_8_13, c_done_8_13, 24'h011235, 0);
        run_walk("p25",  4'd2, 4'd5,  1, 1'b0, 24'h000003, 0);
        check("p25.term_hold", 32'(term_out), 32'd3);
        run_walk("p53",  4'd5, 4'd3,  0, 1'b0, 24'h000000, 0);
        run_walk("p00",  4'd0, 4'd0,  0, 1'b0, 24'h000000, 0);
        run_walk("pign", 4'd8, 4'd13, c_n_8_13, c_done_8_13, 24'h011235, 2);

        // Abort a walk mid-flight with reset.
        start   = 1'b1;
        term_lo = 4'd8;
        term_hi = 4'd13;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort.step3_idx", 32'(index), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.sv",   32'(step_valid), 32'd0);
        check("abort.term", 32'(term_out), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.err",  32'(error), 32'd0);
        check("abort.idx",  32'(index), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort.quiet_done", 32'(done), 32'd0);
            check("abort.quiet_err",  32'(error), 32'd0);
            check("abort.quiet_busy", 32'(busy), 32'd0);
        end

        run_walk("p12", 4'd1, 4'd2, 2, 1'b1, 24'h000001, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fib_reverse_walker.md
Name: fib_reverse_walker

Overview:
- Sequential inverse of the Fibonacci generator: walks the series backward from a consecutive pair (F(n), F(n+1)) down to (F(0), F(1)) = (0, 1).
- Each step uses subtraction, the inverse of the generator's add: (a, b) -> (b - a, a).
- Reports the index n of the loaded pair, or flags the pair as not a valid consecutive Fibonacci pair.
- Serves as the checker/decoder at the consuming end of the generator's output stream.

Parameters:
- WIDTH, 4, bit width of the term inputs, the internal term registers and term_out.
- IDX_W, 4, width of the index counter and the index output.
- MAX_STEPS, 15, step limit. Used only when FIB_STEP_LIMIT_EN is defined; must be less than 2**IDX_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load request. Sampled only in IDLE.
- term_lo  input  WIDTH  F(n), the lower term of the pair.
- term_hi  input  WIDTH  F(n+1), the upper term of the pair.
- busy  output  1  high while in WALK.
- step_valid  output  1  one-cycle pulse per backward step.
- term_out  output  WIDTH  newly derived lower term (b - a). Valid when step_valid is high.
- done  output  1  one-cycle pulse: walk reached (0, 1).
- error  output  1  one-cycle pulse: pair is invalid.
- index  output  IDX_W  step count. Final n when done is high; steps completed when error is high.

Behaviour:
- Reset: synchronous, active-high. While rst is high at a rising clk edge:
  - state goes to IDLE.
  - busy, step_valid, done and error go to 0.
  - term_out, index and the internal registers a, b go to 0.
  - rst overrides start and aborts a walk in progress; no done/error pulse is emitted for the aborted walk.
- States: IDLE, WALK. All outputs are registered.
- IDLE:
  - If start = 1: a <= term_lo, b <= term_hi, index <= 0, state goes to WALK, busy <= 1.
  - Otherwise hold. done, error and step_valid are 0 in every IDLE cycle except the cycle after exit from WALK.
- WALK, evaluated each edge in priority order:
  1. a == 0 and b == 1: done <= 1, state goes to IDLE, busy <= 0.
  2. a == 0 and b != 1: error <= 1, state goes to IDLE.
  3. b < a (subtract borrow): error <= 1, state goes to IDLE.
  4. Otherwise: a <= b - a, b <= a, index <= index + 1, term_out <= b - a, step_valid <= 1. Stay in WALK.
- Arithmetic: b - a is an unsigned WIDTH-bit subtract. The borrow-out is exactly the b < a test. No widening.
- Termination: a + b strictly decreases on every case-4 step, so every walk ends in done or error.
- Latency: with start sampled at edge k and a valid pair of index N, step_valid pulses at edges k+1 .. k+N and done pulses at edge k+N+1.
- start is ignored while busy; no queuing.
- index holds its final value after done/error until the next accepted start or reset.
- term_out holds the last derived term.
- Index counter wraps modulo 2**IDX_W when FIB_STEP_LIMIT_EN is not defined. The defaults cannot reach the wrap, since the largest 4-bit pair (8, 13) has index 6.

Optional Feature:
- Macro: FIB_STEP_LIMIT_EN.
- Defined: in WALK, if index == MAX_STEPS and none of cases 1-3 apply, error <= 1 and state goes to IDLE. This check has priority over case 4. Bounds walk time for wide WIDTH.
- Undefined: no limit logic, and MAX_STEPS is unused.

Test Plan:
- Reset, then start with (term_lo, term_hi) = (0, 1) -> no step_valid; done = 1 one cycle after the start edge, index = 0, error = 0.
- Start with (8, 13) -> six step_valid pulses with term_out = 5, 3, 2, 1, 1, 0; then done = 1 with index = 6. busy is high for 7 cycles.
- Start with (2, 5) -> one step_valid with term_out = 3; next edge error = 1 with index = 1, done = 0. Start with (5, 3) -> error one cycle after start, index = 0. Start with (0, 0) -> error.
- Start with (8, 13), pulse start again with (0, 1) at step 2 -> second start ignored, walk completes with index = 6. Assert rst at step 3 -> all outputs 0 next edge, no done/error pulse. A fresh start with (1, 2) after reset -> done with index = 2.
- With FIB_STEP_LIMIT_EN defined, MAX_STEPS = 3, start (8, 13) -> three step_valid pulses, then error = 1 with index = 3. Same stimulus without the macro -> done with index = 6.
